// File: rtl/ram_delay_mc.sv
`default_nettype none
// ============================================================================
//  Module      : ram_delay_mc
//  Description : Multi-channel programmable delay line built on one shared
//                dual-port RAM. P_NCHAN lanes move in lock-step. Each output
//                sample is the word written exactly dly write strobes
//                earlier. The block tracks how full the line is, passes data
//                straight through when the delay is zero, and re-primes
//                cleanly when the delay changes or clr is pulsed.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_delay_mc #(
    parameter int P_NBITS_DATA = 42,
    parameter int P_NBITS_ADDR = 9,
    parameter int P_NCHAN      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [P_NBITS_ADDR-1:0]           delay_len,
    input  logic                              clr,
    input  logic                              wr,
    input  logic [P_NCHAN*P_NBITS_DATA-1:0]   d,
    output logic [P_NCHAN*P_NBITS_DATA-1:0]   q,
    output logic                              valid,
    output logic                              primed
);

    localparam int c_WORD_W = P_NCHAN * P_NBITS_DATA;
    localparam int c_DEPTH  = 1 << P_NBITS_ADDR;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_FILL   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Shared storage. Lanes are packed side by side in each word, so the
    // channels can never mix: every lane sees the same address on the same
    // cycle.
    logic [c_WORD_W-1:0]     r_mem [c_DEPTH];

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [P_NBITS_ADDR-1:0] r_dly;
    logic [P_NBITS_ADDR-1:0] w_dly_nxt;
    logic [P_NBITS_ADDR-1:0] r_fill;
    logic [P_NBITS_ADDR-1:0] w_fill_nxt;
    logic [P_NBITS_ADDR-1:0] w_fill_inc;
    logic [P_NBITS_ADDR-1:0] r_wr_ptr;
    logic [P_NBITS_ADDR-1:0] w_rd_addr;

    logic                    w_reprime;
    logic                    w_rd_en;
    logic                    w_byp_en;

    logic [c_WORD_W-1:0]     r_q;
    logic                    r_valid;
    logic                    r_primed;

    // A new delay or an explicit clear throws away the current fill.
    assign w_reprime  = (delay_len != r_dly) || clr;

    // The read address trails the write pointer by the active delay; the
    // modulo-depth arithmetic comes for free from the fixed width.
    assign w_rd_addr  = r_wr_ptr - r_dly;
    assign w_fill_inc = r_fill + P_NBITS_ADDR'(1);

    // Next-state, fill accounting and read/bypass enables.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_fill_nxt  = r_fill;
        w_rd_en     = 1'b0;
        w_byp_en    = 1'b0;

        if (w_reprime) begin
            // A write in this cycle still lands in RAM but is not counted.
            w_dly_nxt   = delay_len;
            w_fill_nxt  = '0;
            w_state_nxt = (delay_len == '0) ? ST_BYPASS : ST_FILL;
        end else if (wr) begin
            case (r_state)
                ST_FILL: begin
                    // The write that completes the fill produces no output;
                    // the first read happens on the following write.
                    w_fill_nxt = w_fill_inc;
                    if (w_fill_inc == r_dly) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_rd_en = 1'b1;
                end
                ST_BYPASS: begin
                    w_byp_en = 1'b1;
                end
                default: begin
                    // Unreachable encoding: recover by re-priming.
                    w_fill_nxt  = '0;
                    w_state_nxt = (r_dly == '0) ? ST_BYPASS : ST_FILL;
                end
            endcase
        end
    end

    // Control state: active delay, fill count, write pointer and FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_BYPASS;
            r_dly    <= '0;
            r_fill   <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dly    <= w_dly_nxt;
            r_fill   <= w_fill_nxt;
            if (wr) begin
                r_wr_ptr <= r_wr_ptr + P_NBITS_ADDR'(1);
            end
        end
    end

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[r_wr_ptr] <= d;
        end
    end

    // Output register doubles as the synchronous RAM read register; in
    // bypass it captures d instead, so q is never combinational from d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q      <= '0;
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_valid  <= w_rd_en || w_byp_en;
            r_primed <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_BYPASS);
            if (w_rd_en) begin
                r_q <= r_mem[w_rd_addr];
            end else if (w_byp_en) begin
                r_q <= d;
            end
        end
    end

    assign q      = r_q;
    assign valid  = r_valid;
    assign primed = r_primed;

endmodule
`default_nettype wire

// File: tb/tb_ram_delay_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_delay_mc
//  Description : Directed, table-driven bench for ram_delay_mc. A default
//                instance (9-bit address) covers fill, gaps, delay change,
//                clr, bypass and async reset; a 4-bit-address instance
//                covers maximum delay across pointer wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_delay_mc;

    localparam int c_DW = 42;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic [8:0]        delay_len = 9'd4;
    logic              clr = 1'b0;
    logic              wr  = 1'b0;
    logic [2*c_DW-1:0] d   = '0;
    logic [2*c_DW-1:0] q;
    logic              valid;
    logic              primed;

    logic [3:0]        w_delay_len = 4'd15;
    logic              w_wr = 1'b0;
    logic [2*c_DW-1:0] w_d  = '0;
    logic [2*c_DW-1:0] w_q;
    logic              w_valid;
    logic              w_primed;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_delay_mc #(.P_NBITS_DATA(c_DW), .P_NBITS_ADDR(9), .P_NCHAN(2)) u_dut (
        .clk(clk), .rst(rst), .delay_len(delay_len), .clr(clr), .wr(wr),
        .d(d), .q(q), .valid(valid), .primed(primed)
    );

    ram_delay_mc #(.P_NBITS_DATA(c_DW), .P_NBITS_ADDR(4), .P_NCHAN(2)) u_dut_w (
        .clk(clk), .rst(rst), .delay_len(w_delay_len), .clr(1'b0), .wr(w_wr),
        .d(w_d), .q(w_q), .valid(w_valid), .primed(w_primed)
    );

    typedef struct {
        int     dly;
        bit     clr;
        bit     wr;
        longint d0;
        longint d1;
        bit     ev;
        longint q0;
        longint q1;
        bit     ep;
    } vec_t;

    vec_t vt[$];

    function automatic void add(int dly, bit c, bit w, longint d0, longint d1,
                                bit ev, longint q0, longint q1, bit ep);
        vec_t v;
        v = '{dly, c, w, d0, d1, ev, q0, q1, ep};
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        delay_len = 9'(v.dly);
        clr       = v.clr;
        wr        = v.wr;
        d         = {c_DW'(v.d1), c_DW'(v.d0)};
        @(posedge clk);
        #1;
        check({tag, " valid"},  64'(valid),          64'(v.ev));
        check({tag, " q0"},     64'(q[c_DW-1:0]),    64'(v.q0));
        check({tag, " q1"},     64'(q[2*c_DW-1:c_DW]), 64'(v.q1));
        check({tag, " primed"}, 64'(primed),         64'(v.ep));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst valid",  64'(valid),  64'd0);
        check("rst q",      64'(q),      64'd0);
        check("rst primed", 64'(primed), 64'd0);
        check("rst w_valid", 64'(w_valid), 64'd0);
        rst = 1'b0;

        // Idle cycle absorbs the re-prime from delay 0 to 4
        add(4, 0, 0, 0, 0, 0, 0, 0, 0);
        // Baseline: 10 writes at delay 4
        for (int k = 1; k <= 10; k++)
            add(4, 0, 1, k, 100 + k, k >= 5, (k >= 5) ? k - 4 : 0,
                (k >= 5) ? 100 + k - 4 : 0, k >= 4);
        // Gap: q holds
        add(4, 0, 0, 0, 0, 0, 6, 106, 1);
        add(4, 0, 0, 0, 0, 0, 6, 106, 1);
        for (int k = 11; k <= 14; k++)
            add(4, 0, 1, k, 100 + k, 1, k - 4, 100 + k - 4, 1);
        // Delay change 4 -> 2 alongside write of 50
        add(2, 0, 1, 50, 150, 0, 10, 110, 0);
        add(2, 0, 1, 51, 151, 0, 10, 110, 0);
        add(2, 0, 1, 52, 152, 0, 10, 110, 1);
        add(2, 0, 1, 53, 153, 1, 51, 151, 1);
        add(2, 0, 1, 54, 154, 1, 52, 152, 1);
        // clr mid-RUN
        add(2, 1, 0, 0, 0, 0, 52, 152, 0);
        add(2, 0, 1, 60, 160, 0, 52, 152, 0);
        add(2, 0, 1, 61, 161, 0, 52, 152, 1);
        add(2, 0, 1, 62, 162, 1, 60, 160, 1);
        // Bypass
        add(0, 0, 0, 0, 0, 0, 60, 160, 1);
        add(0, 0, 1, 'h2A, 'h155, 1, 'h2A, 'h155, 1);
        add(0, 0, 1, 'h2B, 'h156, 1, 'h2B, 'h156, 1);
        add(0, 0, 0, 0, 0, 0, 'h2B, 'h156, 1);
        // Back to delay 3
        add(3, 0, 0, 0, 0, 0, 'h2B, 'h156, 0);
        add(3, 0, 1, 70, 170, 0, 'h2B, 'h156, 0);
        add(3, 0, 1, 71, 171, 0, 'h2B, 'h156, 0);
        add(3, 0, 1, 72, 172, 0, 'h2B, 'h156, 1);
        add(3, 0, 1, 73, 173, 1, 70, 170, 1);

        foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

        // Async reset mid-burst: outputs drop without a clock edge
        @(negedge clk);
        wr  = 1'b1;
        d   = {c_DW'(174), c_DW'(74)};
        rst = 1'b1;
        #1;
        check("arst valid",  64'(valid),  64'd0);
        check("arst q",      64'(q),      64'd0);
        check("arst primed", 64'(primed), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        vt.delete();
        add(3, 0, 0, 0, 0, 0, 0, 0, 0);
        add(3, 0, 1, 80, 180, 0, 0, 0, 0);
        add(3, 0, 1, 81, 181, 0, 0, 0, 0);
        add(3, 0, 1, 82, 182, 0, 0, 0, 1);
        add(3, 0, 1, 83, 183, 1, 80, 180, 1);
        foreach (vt[i]) apply(vt[i], $sformatf("post_rst%0d", i));

        // Maximum delay across pointer wrap on the 4-bit-address instance
        @(negedge clk);
        wr = 1'b0;
        for (int v = 0; v < 40; v++) begin
            @(negedge clk);
            w_wr = 1'b1;
            w_d  = {c_DW'(1000 + v), c_DW'(v)};
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d valid", v),  64'(w_valid),  64'(v >= 15));
            check($sformatf("wrap%0d primed", v), 64'(w_primed), 64'(v >= 14));
            check($sformatf("wrap%0d q0", v), 64'(w_q[c_DW-1:0]),
                  (v >= 15) ? 64'(v - 15) : 64'd0);
            check($sformatf("wrap%0d q1", v), 64'(w_q[2*c_DW-1:c_DW]),
                  (v >= 15) ? 64'(1000 + v - 15) : 64'd0);
        end
        @(negedge clk);
        w_wr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_delay_mc.md
# ram_delay_mc

Multi-channel, write-strobe-driven programmable delay line with asynchronous reset. It is the parametrised successor to the single-channel RAM delay. It delays P_NCHAN lanes in lock-step through one shared dual-port RAM of depth 2^P_NBITS_ADDR. Each accepted output sample is the one written exactly dly write strobes earlier. It adds fill tracking, a zero-delay bypass mode, and clean re-priming on delay change or clear. It sits in the trigger/data path ahead of the event builder, aligning data with late-arriving trigger decisions.

## Interface
- P_NBITS_DATA, 42, bits per channel
- P_NBITS_ADDR, 9, RAM address width; RAM depth 2^P_NBITS_ADDR; max delay 2^P_NBITS_ADDR-1
- P_NCHAN, 2, number of lock-step channels; RAM word = P_NCHAN*P_NBITS_DATA

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- delay_len  in  P_NBITS_ADDR  requested delay in write strobes; quasi-static
- clr  in  1  synchronous re-prime request (single-cycle pulse)
- wr  in  1  write strobe; d accepted when high
- d  in  P_NCHAN*P_NBITS_DATA  input word; channel c at [c*P_NBITS_DATA +: P_NBITS_DATA]
- q  out  P_NCHAN*P_NBITS_DATA  delayed word, same lane packing
- valid  out  1  q updated with a delayed sample this cycle
- primed  out  1  delay line is full at current delay (state RUN or BYPASS)

## Operation
- Registers:
  - dly_r: active delay
  - wr_ptr: write address, wraps modulo 2^P_NBITS_ADDR
  - fill_cnt: P_NBITS_ADDR bits, saturates at dly_r
  - state: BYPASS, FILL, RUN
- Reset values:
  - q=0, valid=0, primed=0
  - wr_ptr=0, fill_cnt=0, dly_r=0, state=BYPASS
  - RAM contents are not reset.
- Re-prime event: delay_len != dly_r, or clr=1. On this event:
  - dly_r<=delay_len
  - fill_cnt<=0
  - state<=BYPASS if delay_len==0, else FILL
  - A wr in the same cycle is written to RAM and advances wr_ptr. It is not counted and produces no valid.
- FILL: each wr writes d at wr_ptr, wr_ptr+1, fill_cnt+1. When fill_cnt reaches dly_r, go to RUN.
  - Exception: the write that takes fill_cnt from dly_r-1 to dly_r still produces no output; valid stays low.
- RUN: each wr writes d at wr_ptr and reads RAM at (wr_ptr - dly_r) mod depth, read and write in the same cycle. Next cycle: q=read word, valid=1.
  - The two addresses never coincide, since 1 <= dly_r <= depth-1.
- BYPASS (dly_r==0): on wr, q<=d and valid<=1 next cycle. RAM writes and wr_ptr continue.
- wr=0 in any state: valid<=0, q holds, pointers hold.
- primed = (state==RUN) || (state==BYPASS), registered.
- All channels share the pointers, fill count and valid; channel data never mixes across lanes.

## Timing
- Latency is 1 clk from the wr edge to valid/q in RUN and BYPASS.
- RAM read is synchronous, read-first; q is taken directly from the RAM output register. No combinational path from d to q.
- Re-prime takes effect at the edge where the event is sampled:
  - valid=0 from the next cycle.
  - primed falls the next cycle.
  - primed rises the cycle after the dly_r-th counted write.
- First valid after re-prime is on the (dly_r+1)-th counted write, observed +1 cycle.
- Back-to-back wr gives one valid per cycle, sustained indefinitely; pointer wrap is seamless.
- Async rst mid-stream: outputs drop immediately. After release, the block re-primes from an empty, unprimed state.

## Test plan
- Baseline, delay_len=4, P_NCHAN=2: 10 consecutive wr with lane0=1..10 and lane1=101..110.
  - Expect 6 valid pulses, starting the cycle after the 5th write.
  - Lane0 q=1..6, lane1 q=101..106.
  - primed rises after the 4th write.
- Gap handling: continue the baseline with wr=0 for 2 cycles.
  - Expect valid=0, q held at 6/106.
  - Then 4 more writes 11..14 → q=7..10, one valid per write.
- Bypass, delay_len=0: wr with d=0x2A → next cycle valid=1, q=0x2A. primed=1 throughout.
- Delay change: in RUN at delay 4, change delay_len to 2 concurrently with a write of 50, then write 51, 52, 53.
  - Expect no valid for 50, 51, 52.
  - The write of 53 outputs q=51.
- Wrap and max depth: P_NBITS_ADDR=4, delay_len=15, write 0..39 continuously.
  - First valid is on the 16th write, with q=0.
  - Thereafter q = written value minus 15 across pointer wrap.
- clr and async rst: pulse clr mid-RUN → primed=0 and refill as for re-prime. Assert rst mid-burst → valid/q/primed=0 immediately and the stream re-primes after release.
